// File: rtl/ssp_tx_fifo.sv
// SSP transmit FIFO: bus-side push, shifter-side pop, full raises SSPTXINTR.
// Optional sticky overrun flag TxOvr is built only when TX_FIFO_OVR_EN is defined.
module ssp_tx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              PCLK_TX,
    input  logic              CLEAR_B_TX,
    input  logic              PSEL_TX,
    input  logic              PWRITE_TX,
    input  logic [DATA_W-1:0] PWDATA_TX,
    input  logic              TxRdy,
    output logic [DATA_W-1:0] TxData,
    output logic              TxValid,
    output logic              TxEmpty,
    output logic              SSPTXINTR,
    output logic              TxOvr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0][DATA_W-1:0] mem;
    logic [AW-1:0]                wr_ptr, rd_ptr;
    logic [CW-1:0]                count;
    logic                         full, empty, wr_req, push, pop;

    // Full/empty are judged on the pre-edge count, so a refused push never
    // blocks a pop in the same cycle and vice versa.
    assign full   = (count == CW'(DEPTH));
    assign empty  = (count == '0);
    assign wr_req = PSEL_TX & PWRITE_TX;
    assign push   = wr_req & ~full;
    assign pop    = TxRdy & ~empty;

    always_ff @(posedge PCLK_TX) begin
        if (!CLEAR_B_TX) begin
            mem     <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            TxData  <= '0;
            TxValid <= 1'b0;
        end else begin
            TxValid <= pop;
            if (push) begin
                mem[wr_ptr] <= PWDATA_TX;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                TxData <= mem[rd_ptr];
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
        end
    end

    assign TxEmpty   = empty;
    assign SSPTXINTR = full;

`ifdef TX_FIFO_OVR_EN
    logic ovr_q;

    always_ff @(posedge PCLK_TX) begin
        if (!CLEAR_B_TX)
            ovr_q <= 1'b0;
        else if (wr_req && full)
            ovr_q <= 1'b1;
    end

    assign TxOvr = ovr_q;
`else
    assign TxOvr = 1'b0;
`endif

endmodule

// File: tb/tb_ssp_tx_fifo.sv
// Directed self-checking bench for ssp_tx_fifo (DATA_W=8, DEPTH=4).
// Overrun expectations follow whether TX_FIFO_OVR_EN is defined for the build.
module tb_ssp_tx_fifo;

    logic       clk;
    logic       clr_b;
    logic       psel;
    logic       pwrite;
    logic [7:0] pwdata;
    logic       rdy;
    logic [7:0] tx_data;
    logic       tx_valid, tx_empty, tx_intr, tx_ovr;

    int n_chk = 0;
    int n_err = 0;

`ifdef TX_FIFO_OVR_EN
    localparam logic OVR_EXP = 1'b1;
`else
    localparam logic OVR_EXP = 1'b0;
`endif

    ssp_tx_fifo #(.DATA_W(8), .DEPTH(4)) dut (
        .PCLK_TX   (clk),
        .CLEAR_B_TX(clr_b),
        .PSEL_TX   (psel),
        .PWRITE_TX (pwrite),
        .PWDATA_TX (pwdata),
        .TxRdy     (rdy),
        .TxData    (tx_data),
        .TxValid   (tx_valid),
        .TxEmpty   (tx_empty),
        .SSPTXINTR (tx_intr),
        .TxOvr     (tx_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clr_b = 1'b0; psel = 1'b0; pwrite = 1'b0; rdy = 1'b0;
        step();
        clr_b = 1'b1;
    endtask

    task automatic push_only(input logic [7:0] d);
        psel = 1'b1; pwrite = 1'b1; pwdata = d; rdy = 1'b0;
        step();
        psel = 1'b0; pwrite = 1'b0;
    endtask

    task automatic pop_only();
        psel = 1'b0; pwrite = 1'b0; rdy = 1'b1;
        step();
        rdy = 1'b0;
    endtask

    initial begin
        // Clear with every other input asserted
        clr_b = 1'b0; psel = 1'b1; pwrite = 1'b1; pwdata = 8'hAA; rdy = 1'b1;
        step();
        chk("clr_data",  tx_data,  8'h00);
        chk("clr_valid", tx_valid, 1'b0);
        chk("clr_empty", tx_empty, 1'b1);
        chk("clr_intr",  tx_intr,  1'b0);
        chk("clr_ovr",   tx_ovr,   1'b0);
        clr_b = 1'b1; psel = 1'b0; pwrite = 1'b0; rdy = 1'b0;

        // Fill
        push_only(8'h11);
        chk("fill1_empty", tx_empty, 1'b0);
        chk("fill1_intr",  tx_intr,  1'b0);
        push_only(8'h22);
        push_only(8'h33);
        chk("fill3_intr",  tx_intr,  1'b0);
        push_only(8'h44);
        chk("fill4_intr",  tx_intr,  1'b1);
        chk("fill4_empty", tx_empty, 1'b0);

        // Overrun: dropped write
        push_only(8'h55);
        chk("ovr_intr", tx_intr, 1'b1);
        chk("ovr_flag", tx_ovr,  OVR_EXP);

        // Drain with TxRdy held high
        psel = 1'b0; pwrite = 1'b0; rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("drain_data",  tx_data,  8'h11 * (i + 1));
            chk("drain_valid", tx_valid, 1'b1);
        end
        chk("drain_empty", tx_empty, 1'b1);
        step();
        chk("drain_end_valid", tx_valid, 1'b0);
        chk("drain_end_hold",  tx_data,  8'h44);
        chk("drain_end_empty", tx_empty, 1'b1);
        chk("ovr_persist",     tx_ovr,   OVR_EXP);
        rdy = 1'b0;

        do_clear();
        chk("ovr_cleared", tx_ovr, 1'b0);

        // Full with simultaneous push and pop
        push_only(8'h11);
        push_only(8'h22);
        push_only(8'h33);
        push_only(8'h44);
        psel = 1'b1; pwrite = 1'b1; pwdata = 8'h66; rdy = 1'b1;
        step();
        chk("fullsim_data",  tx_data,  8'h11);
        chk("fullsim_valid", tx_valid, 1'b1);
        chk("fullsim_intr",  tx_intr,  1'b0);
        chk("fullsim_ovr",   tx_ovr,   OVR_EXP);
        psel = 1'b0; pwrite = 1'b0;
        step();
        chk("fullsim_d2", tx_data, 8'h22);
        step();
        chk("fullsim_d3", tx_data, 8'h33);
        step();
        chk("fullsim_d4",    tx_data,  8'h44);
        chk("fullsim_empty", tx_empty, 1'b1);
        rdy = 1'b0;

        // Empty with simultaneous push and pop
        psel = 1'b1; pwrite = 1'b1; pwdata = 8'h77; rdy = 1'b1;
        step();
        chk("emptysim_valid", tx_valid, 1'b0);
        chk("emptysim_empty", tx_empty, 1'b0);
        chk("emptysim_hold",  tx_data,  8'h44);
        pop_only();
        chk("emptysim_data",  tx_data,  8'h77);
        chk("emptysim_v2",    tx_valid, 1'b1);
        chk("emptysim_empty2", tx_empty, 1'b1);

        // Interleaved stream across two pointer wraps
        for (int i = 0; i <= 10; i++) begin
            psel = (i < 10); pwrite = (i < 10); pwdata = 8'(i + 1);
            rdy = (i >= 1);
            step();
            if (i >= 1) begin
                chk("wrap_data",  tx_data,  32'(i));
                chk("wrap_valid", tx_valid, 1'b1);
            end
        end
        psel = 1'b0; pwrite = 1'b0; rdy = 1'b0;
        chk("wrap_empty", tx_empty, 1'b1);

        // Clear while holding entries with a pop pending
        push_only(8'hA1);
        push_only(8'hA2);
        push_only(8'hA3);
        clr_b = 1'b0; rdy = 1'b1;
        step();
        chk("midclr_valid", tx_valid, 1'b0);
        chk("midclr_empty", tx_empty, 1'b1);
        chk("midclr_data",  tx_data,  8'h00);
        clr_b = 1'b1;
        step();
        chk("midclr_pop_valid", tx_valid, 1'b0);
        chk("midclr_pop_empty", tx_empty, 1'b1);
        rdy = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ssp_tx_fifo.md
# ssp_tx_fifo

Transmit-side FIFO of the SSP peripheral. The CPU pushes bytes over the APB-style select/write strobe, and the serial shift logic pops them with a one-signal request. It is the counterpart of the receive FIFO: same bus flavour and clear convention, with data flowing from bus to line. It raises SSPTXINTR while full so software stops writing.

## Interface
- DATA_W, 8, data width in bits
- DEPTH, 4, number of entries; power of two, ≥2
- PCLK_TX  in  1  sole clock; all state updates on rising edge
- CLEAR_B_TX  in  1  reset, synchronous, active-low
- PSEL_TX  in  1  peripheral select; qualifies bus writes
- PWRITE_TX  in  1  1 = bus write (push); 0 = no bus action
- PWDATA_TX  in  DATA_W  byte to push
- TxRdy  in  1  pop request from serial shifter, level-sampled each edge
- TxData  out  DATA_W  popped byte, registered
- TxValid  out  1  one-cycle pulse: TxData updated this cycle
- TxEmpty  out  1  FIFO holds 0 entries
- SSPTXINTR  out  1  FIFO holds DEPTH entries (full)
- TxOvr  out  1  sticky overrun flag (see Configuration)

## Operation
- State:
  - mem[0:DEPTH-1], DATA_W wide.
  - wr_ptr, rd_ptr, each log2(DEPTH) bits; wrap modulo DEPTH naturally.
  - count, log2(DEPTH)+1 bits, range 0..DEPTH.
- Clear (CLEAR_B_TX=0 at edge), regardless of PSEL_TX and all other inputs:
  - Zeroes mem, wr_ptr, rd_ptr, count, TxData, TxValid, TxOvr.
  - Resulting outputs: TxEmpty=1, SSPTXINTR=0.
- push = PSEL_TX & PWRITE_TX & (count != DEPTH).
  - mem[wr_ptr] <= PWDATA_TX; wr_ptr++.
- pop = TxRdy & (count != 0).
  - TxData <= mem[rd_ptr]; rd_ptr++; TxValid <= 1.
  - No pop: TxValid <= 0. TxData holds its last value.
- count update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on both or neither.
- Full and empty are judged on the pre-edge count:
  - Full, push+pop same cycle: push refused, pop proceeds, count becomes DEPTH−1.
  - Empty, push+pop same cycle: pop refused (TxValid=0), push proceeds, count becomes 1.
- Write attempted while full (PSEL_TX & PWRITE_TX & count==DEPTH): data dropped, mem and pointers unchanged, overrun event raised.
- PSEL_TX=0 or PWRITE_TX=0: no push. TxRdy still pops independently of PSEL_TX.
- Status outputs are decodes of the count register:
  - TxEmpty = (count==0).
  - SSPTXINTR = (count==DEPTH).

## Timing
- Push-to-pop latency:
  - A byte pushed at edge N is poppable at edge N+1 at the earliest.
  - If TxRdy=1 at edge N+1, the byte appears on TxData with TxValid=1 after edge N+1.
- Pop latency: TxRdy high at edge N → TxData/TxValid valid in cycle after edge N.
- TxRdy held high drains one entry per cycle. TxValid stays high for consecutive pops and drops the cycle after the last one.
- Status outputs update in the same cycle as count, one cycle after the causing edge.
- Clear mid-stream: takes effect at that edge. A pending push or pop in the same cycle is discarded, and TxValid=0 the following cycle.
- FIFO order is strict. Pointer wrap is invisible: the entry after index DEPTH−1 is index 0.

## Configuration
- TX_FIFO_OVR_EN defined:
  - TxOvr sets to 1 on any write attempt while full.
  - It stays 1 until clear; further pushes and pops do not change it.
- TX_FIFO_OVR_EN undefined: TxOvr is constant 0 and no overrun logic is built. Dropped writes are silent; all other behaviour is identical.

## Test plan
- Clear: CLEAR_B_TX=0 one edge with PSEL_TX=PWRITE_TX=TxRdy=1 → TxData=0x00, TxValid=0, TxEmpty=1, SSPTXINTR=0, TxOvr=0.
- Fill and drain:
  - Push 0x11,0x22,0x33,0x44 → SSPTXINTR=1 after 4th edge, TxEmpty=0.
  - Then TxRdy=1 for 4 cycles → TxData 0x11,0x22,0x33,0x44 on consecutive cycles with TxValid=1. Afterwards TxEmpty=1, TxValid=0.
- Overrun:
  - When full, push 0x55 → contents unchanged (drain yields 0x11..0x44).
  - TxOvr=1 with TX_FIFO_OVR_EN, 0 without. TxOvr persists after drain until clear.
- Simultaneous at boundaries:
  - When full, push 0x66 + TxRdy → pops 0x11, 0x66 dropped, count 3.
  - When empty, push 0x77 + TxRdy → TxValid=0, count 1; next TxRdy yields 0x77.
- Wrap-around:
  - Push and pop interleaved 10 bytes 0x01..0x0A while keeping count ≤2 → output order 0x01..0x0A exact, pointers wrap twice without loss.
- Clear mid-operation: 3 entries held, CLEAR_B_TX=0 with TxRdy=1 → no TxValid. Subsequent pop with no push yields TxValid=0, TxEmpty=1.
